// File: rtl/imem_loader.sv
// Boot loader: assembles a byte stream into 32-bit little-endian words, writes them to imem,
// and releases the CPU from reset after the XOR checksum matches. Accepts one byte per cycle.
module imem_loader #(
    parameter int IMEM_DEPTH      = 1024,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    input  logic                       restart,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_reset_b,
    output logic                       load_done,
    output logic                       load_error,
    output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH_EXT = 17'(IMEM_DEPTH);

    state_t                     state;
    state_t                     state_nxt;
    logic [15:0]                count;
    logic [1:0]                 byte_idx;
    logic [23:0]                asm_q;
    logic [7:0]                 csum;
    logic [IMEM_ADDR_WIDTH-1:0] word_idx;

    logic                       accept;
    logic                       restart_take;
    logic [15:0]                count_full;
    logic [15:0]                wl_next;
    logic                       last_word;

    assign accept       = rx_valid && rx_ready;
    assign restart_take = restart && ((state == DONE) || (state == ERROR));
    assign count_full   = {rx_data, count[7:0]};
    // words_loaded counts words already written, so +1 is the word now being completed
    assign wl_next      = {{(15 - IMEM_ADDR_WIDTH){1'b0}}, words_loaded} + 16'd1;
    assign last_word    = (byte_idx == 2'd3) && (wl_next == count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CNT_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rx_ready    = 1'b0;
        load_done   = 1'b0;
        load_error  = 1'b0;
        cpu_reset_b = 1'b0;
        case (state)
            CNT_LO: begin
                rx_ready = 1'b1;
                if (accept) state_nxt = CNT_HI;
            end
            CNT_HI: begin
                rx_ready = 1'b1;
                if (accept) begin
                    if ({1'b0, count_full} > DEPTH_EXT) begin
                        state_nxt = ERROR;
                    end else if (count_full == 16'd0) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (accept && last_word) state_nxt = CHECK;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
            end
            DONE: begin
                load_done   = 1'b1;
                cpu_reset_b = 1'b1;
                if (restart) state_nxt = CNT_LO;
            end
            ERROR: begin
                load_error = 1'b1;
                if (restart) state_nxt = CNT_LO;
            end
            default: state_nxt = CNT_LO;
        endcase
        // rx_ready must read low for the whole time reset is held, not just after the edge
        if (reset) rx_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
            csum         <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (restart_take) begin
                count        <= '0;
                byte_idx     <= '0;
                csum         <= '0;
                word_idx     <= '0;
                words_loaded <= '0;
            end
            if (accept) begin
                case (state)
                    CNT_LO: count[7:0]  <= rx_data;
                    CNT_HI: count[15:8] <= rx_data;
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {rx_data, asm_q};
                            imem_waddr   <= word_idx;
                            word_idx     <= word_idx + 1'b1;
                            words_loaded <= words_loaded + 1'b1;
                        end else begin
                            asm_q[byte_idx*8 +: 8] <= rx_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are checked against a stream-level model of the load.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          restart;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset_b;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    imem_loader #(.IMEM_DEPTH(DEPTH), .IMEM_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_reset_b  (cpu_reset_b),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  stim[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    bit          exp_done;
    int          exp_wl;
    int          exp_len;
    bit          prev_crb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                got_addr.push_back(int'(imem_waddr));
                got_data.push_back(imem_wdata);
            end
            if (cpu_reset_b && !prev_crb) chk("release_not_with_we", {31'b0, imem_we}, 32'd0);
        end
        prev_crb = cpu_reset_b;
    end

    // Stream-level reference: what the load of stim must produce.
    task automatic model();
        int         n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'(stim[0]) + 256 * int'(stim[1]);
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_wl   = 0;
            exp_len  = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
            for (int k = 0; k < 4; k++) x = x ^ stim[2+4*i+k];
        end
        exp_len  = 3 + 4 * n;
        exp_done = (stim[2+4*n] == x);
        exp_wl   = n;
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                stim.push_back(b);
                x = x ^ b;
            end
            if (corrupt) x = x ^ 8'($urandom_range(1, 255));
            stim.push_back(x);
        end
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (rx_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_crb_low", {31'b0, cpu_reset_b}, 32'd0);
        chk("restart_rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("restart_flags", {30'b0, load_done, load_error}, 32'd0);
        chk("restart_wl", 32'(words_loaded), 32'd0);
    endtask

    task automatic run_load(input int mode);
        int nw;
        model();
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < exp_len; i++) send_byte(stim[i], gap_for(mode));
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("n_writes", 32'(got_addr.size()), 32'(exp_addr.size()));
        nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            chk("waddr", 32'(got_addr[i]), 32'(exp_addr[i]));
            chk("wdata", got_data[i], exp_data[i]);
        end
        chk("load_done", {31'b0, load_done}, {31'b0, exp_done});
        chk("load_error", {31'b0, load_error}, {31'b0, !exp_done});
        chk("cpu_reset_b", {31'b0, cpu_reset_b}, {31'b0, exp_done});
        chk("words_loaded", 32'(words_loaded), 32'(exp_wl));
        chk("rx_ready_end", {31'b0, rx_ready}, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("stray_state", {30'b0, load_done, load_error}, {30'b0, exp_done, !exp_done});
        chk("stray_no_write", 32'(got_addr.size()), 32'(exp_addr.size()));
        chk("stray_rx_ready", {31'b0, rx_ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_we_addr_data", {imem_we, 21'b0, imem_waddr} | imem_wdata, 32'd0);
        chk("rst_flags", {29'b0, cpu_reset_b, load_done, load_error}, 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        #1 chk("post_rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);

        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        run_load(0);
        chk("nominal_w0", got_data[0], 32'h00100513);
        chk("nominal_w1", got_data[1], 32'h00200593);
        chk("nominal_done", {31'b0, load_done}, 32'd1);
        do_restart();
        run_load(0);
        chk("reload_addr0", 32'(got_addr[0]), 32'd0);
        do_restart();

        stim[10] = 8'hB1;
        run_load(0);
        chk("badsum_error", {31'b0, load_error}, 32'd1);
        do_restart();

        build(1025, 1'b0);
        run_load(0);
        chk("len1025_no_write", 32'(got_addr.size()), 32'd0);
        do_restart();

        build(1024, 1'b0);
        run_load(0);
        chk("len1024_last_addr", 32'(got_addr[$]), 32'd1023);
        chk("len1024_wl", 32'(words_loaded), 32'd1024);
        do_restart();

        stim = '{8'h00, 8'h00, 8'h00};
        run_load(2);
        chk("zero_done", {31'b0, load_done}, 32'd1);
        do_restart();
        stim = '{8'h00, 8'h00, 8'h05};
        run_load(2);
        chk("zero_bad_error", {31'b0, load_error}, 32'd1);
        do_restart();

        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        run_load(1);
        do_restart();

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 7) == 0) build(int'($urandom_range(1025, 1100)), 1'b0);
            else build(int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
            run_load(int'($urandom_range(0, 2)));
            do_restart();
        end

        build(2, 1'b0);
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < 8; i++) send_byte(stim[i], 0);
        rx_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("midrst_we_addr_data", {imem_we, 21'b0, imem_waddr} | imem_wdata, 32'd0);
        chk("midrst_flags", {29'b0, cpu_reset_b, load_done, load_error}, 32'd0);
        chk("midrst_wl", 32'(words_loaded), 32'd0);
        chk("midrst_one_write", 32'(got_addr.size()), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_more_writes", 32'(got_addr.size()), 32'd1);
        chk("midrst_rx_ready_after", {31'b0, rx_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
